// File: rtl/stopwatch_bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble, one bit per cycle) driving a
// multiplexed active-high 7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module stopwatch_bcd_display #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DIGITS      = 5,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned IterW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IterW-1:0] LastIter = IterW'(DATA_WIDTH - 1);
  localparam logic [RefW-1:0]  LastRef  = RefW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] held;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BcdW-1:0]       scratch;
  logic [IterW-1:0]      iter;

  logic [BcdW-1:0]       scratch_adj;
  logic [BcdW-1:0]       scratch_next;
  logic [DATA_WIDTH-1:0] shreg_next;

  logic [RefW-1:0]       refresh_cnt;
  logic [IdxW-1:0]       idx;
  logic [3:0]            nibble;
  logic                  blank;

  // One double-dabble iteration: correct each nibble, then shift the whole chain left.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    {scratch_next, shreg_next} = {scratch_adj, shreg} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      held      <= '0;
      shreg     <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (count != held) begin
            held    <= count;
            shreg   <= count;
            scratch <= '0;
            iter    <= '0;
            busy    <= 1'b1;
            state   <= StShift;
          end
        end
        StShift: begin
          shreg   <= shreg_next;
          scratch <= scratch_next;
          iter    <= iter + IterW'(1);
          if (iter == LastIter) begin
            bcd       <= scratch_next;
            bcd_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Display scan runs continuously regardless of conversion activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == LastRef) begin
      refresh_cnt <= '0;
      idx         <= (idx == LastIdx) ? '0 : idx + IdxW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RefW'(1);
    end
  end

  always_comb begin
    an     = '0;
    nibble = '0;
    blank  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IdxW'(i)) begin
        an[i]  = 1'b1;
        nibble = bcd[4*i +: 4];
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      // Walk down from the top digit; digit 0 is never blanked.
      for (int i = int'(DIGITS) - 1; i > 0; i--) begin
        upper_zero = upper_zero && (bcd[4*i +: 4] == 4'd0);
        if (idx == IdxW'(i)) begin
          blank = upper_zero;
        end
      end
    end
`else
    blank = 1'b0;
`endif
    case (nibble)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    if (blank) begin
      seg = 7'b0000000;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_display.sv
// Directed self-checking bench for stopwatch_bcd_display (REFRESH_DIV=4 to keep scan short).
module tb_stopwatch_bcd_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] count;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  seg;
  logic [4:0]  an;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  stopwatch_bcd_display #(
    .DATA_WIDTH (16),
    .DIGITS     (5),
    .REFRESH_DIV(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .bcd      (bcd),
    .bcd_valid(bcd_valid),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bcd_valid === 1'b1) pulse_cnt = pulse_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply a new count, step through the capture edge, then wait for bcd_valid.
  task automatic drive_and_wait(input logic [15:0] v, output int lat, output int busy_cycles);
    count = v;
    step();
    lat = 0;
    busy_cycles = 0;
    while (bcd_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    int p0;
    reset = 1'b1;
    count = 16'd0;
    repeat (3) step();
    n_cmp++; if (bcd !== 20'h00000) begin n_err++; $display("FAIL reset_bcd: got %h want 00000", bcd); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bcd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bcd_valid); end
    n_cmp++; if (an !== 5'b00001) begin n_err++; $display("FAIL reset_an: got %b want 00001", an); end
    n_cmp++; if (seg !== 7'b0111111) begin n_err++; $display("FAIL reset_seg: got %b want 0111111", seg); end
    p0 = pulse_cnt;
    reset = 1'b0;
    repeat (20) step();
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL idle_no_pulse: got %0d want 0", pulse_cnt - p0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_convert_99();
    int lat, bc, p0;
    p0 = pulse_cnt;
    drive_and_wait(16'd99, lat, bc);
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL lat_99: got %0d want 16", lat); end
    n_cmp++; if (bc !== 16) begin n_err++; $display("FAIL busy_cycles_99: got %0d want 16", bc); end
    n_cmp++; if (bcd !== 20'h00099) begin n_err++; $display("FAIL bcd_99: got %h want 00099", bcd); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_done_99: got %b want 0", busy); end
    step();
    n_cmp++; if (bcd_valid !== 1'b0) begin n_err++; $display("FAIL valid_width_99: got %b want 0", bcd_valid); end
    repeat (5) step();
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL pulses_99: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_extremes();
    int lat, bc, p0;
    p0 = pulse_cnt;
    drive_and_wait(16'd65535, lat, bc);
    n_cmp++; if (bcd !== 20'h65535) begin n_err++; $display("FAIL bcd_65535: got %h want 65535", bcd); end
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL lat_65535: got %0d want 16", lat); end
    repeat (3) step();
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL pulses_65535: got %0d want 1", pulse_cnt - p0); end
    p0 = pulse_cnt;
    drive_and_wait(16'd10, lat, bc);
    n_cmp++; if (bcd !== 20'h00010) begin n_err++; $display("FAIL bcd_10: got %h want 00010", bcd); end
    repeat (3) step();
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL pulses_10: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_coalesce();
    int n, p0;
    p0 = pulse_cnt;
    count = 16'd5;
    step();
    count = 16'd6;
    step();
    count = 16'd7;
    n = 0;
    while (bcd_valid !== 1'b1 && n < 40) begin step(); n++; end
    n_cmp++; if (bcd !== 20'h00005) begin n_err++; $display("FAIL coalesce_first: got %h want 00005", bcd); end
    step();
    n = 0;
    while (bcd_valid !== 1'b1 && n < 40) begin step(); n++; end
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL coalesce_lat: got %0d want 16", n); end
    n_cmp++; if (bcd !== 20'h00007) begin n_err++; $display("FAIL coalesce_final: got %h want 00007", bcd); end
    repeat (25) step();
    n_cmp++; if (pulse_cnt - p0 !== 2) begin n_err++; $display("FAIL coalesce_pulses: got %0d want 2", pulse_cnt - p0); end
  endtask

  task automatic test_scan();
    int lat, bc, n;
    logic [4:0] exp_an;
    logic [6:0] exp_seg;
    drive_and_wait(16'd9, lat, bc);
    n_cmp++; if (bcd !== 20'h00009) begin n_err++; $display("FAIL scan_bcd: got %h want 00009", bcd); end
    n = 0;
    while (an === 5'b00001 && n < 50) begin step(); n++; end
    while (an !== 5'b00001 && n < 50) begin step(); n++; end
    n_cmp++; if (n >= 50) begin n_err++; $display("FAIL scan_sync: got %0d cycles want <50", n); end
    for (int d = 0; d < 6; d++) begin
      exp_an = 5'b00001 << (d % 5);
      if (d % 5 == 0) exp_seg = 7'b1101111;
`ifdef LEADING_ZERO_BLANK_EN
      else exp_seg = 7'b0000000;
`else
      else exp_seg = 7'b0111111;
`endif
      for (int c = 0; c < 4; c++) begin
        n_cmp++; if (an !== exp_an) begin n_err++; $display("FAIL scan_an d%0d c%0d: got %b want %b", d, c, an, exp_an); end
        n_cmp++; if (seg !== exp_seg) begin n_err++; $display("FAIL scan_seg d%0d c%0d: got %b want %b", d, c, seg, exp_seg); end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, p0;
    p0 = pulse_cnt;
    count = 16'd99;
    step();
    repeat (5) step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (bcd !== 20'h00000) begin n_err++; $display("FAIL mid_bcd: got %h want 00000", bcd); end
    repeat (20) step();
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL mid_no_pulse: got %0d want 0", pulse_cnt - p0); end
    reset = 1'b0;
    drive_and_wait(16'd99, lat, bc);
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL mid_relat: got %0d want 16", lat); end
    n_cmp++; if (bcd !== 20'h00099) begin n_err++; $display("FAIL mid_rebcd: got %h want 00099", bcd); end
  endtask

  initial begin
    reset = 1'b1;
    count = 16'd0;
    test_reset();
    test_convert_99();
    test_extremes();
    test_coalesce();
    test_scan();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_display.md
Name: stopwatch_bcd_display

Overview:
Downstream consumer of the stopwatch counter's binary count output. It converts the count to packed BCD with a sequential double-dabble engine, one bit per cycle. It then drives a time-multiplexed, active-high 7-segment display, one digit enabled at a time. It sits between the stopwatch counter and the board display pins.

Parameters:
DATA_WIDTH, 16, width of the incoming binary count; must match the counter stage.
DIGITS, 5, number of BCD digits and display positions; must satisfy DIGITS >= ceil(DATA_WIDTH*0.30103). Violating this is a configuration error; no runtime check.
REFRESH_DIV, 1000, clock cycles each digit stays enabled before the scan advances; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
count  in  DATA_WIDTH  binary value from the stopwatch counter
bcd  out  4*DIGITS  packed BCD, digit 0 (units) in [3:0]; registered
bcd_valid  out  1  one-cycle pulse when bcd is updated
busy  out  1  high while a conversion is in progress
seg  out  7  segments for the enabled digit, {g,f,e,d,c,b,a}, active-high
an  out  DIGITS  one-hot digit enable, active-high

Behaviour:
- Reset (reset=1 at a clock edge):
  - bcd=0, bcd_valid=0, busy=0; state=IDLE; held copy of count=0.
  - Scan index=0, refresh counter=0, an=1 (digit 0).
  - Reset mid-conversion aborts it with no bcd_valid pulse.
- FSM states: IDLE, SHIFT.
- IDLE:
  - Stays in IDLE while count == held.
  - When count != held at an edge: held<=count, shift reg<=count, scratch BCD<=0, iter<=0, state->SHIFT, busy=1 from the next cycle.
- SHIFT, one edge per iteration, DATA_WIDTH iterations:
  - Add 3 to each scratch nibble >= 5.
  - Shift {scratch, shift reg} left by 1.
  - On the edge completing iteration DATA_WIDTH-1: bcd <= final scratch, bcd_valid=1 for exactly the following cycle, busy=0, state->IDLE.
- Latency: bcd updates DATA_WIDTH edges after the capture edge, so 16 for the default.
- count changes during SHIFT are ignored by the running conversion.
  - On return to IDLE the latest count is compared with held and converted if different.
  - Intermediate values are coalesced; the final value is always converted.
- A new capture may occur in the same cycle that bcd_valid is high.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge, the scan index advances 0..DIGITS-1 and wraps to 0.
  - an = one-hot of index.
  - seg = decode of bcd nibble[index], combinational from registered bcd and index.
  - The scan runs continuously, independent of busy.
- Decode table, gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Nibble >9 -> 0000000 (unreachable).

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: seg=0000000 for any digit i>0 whose nibble and all higher nibbles are 0; digit 0 always shown. For example, 42 shows blank,blank,blank,4,2. an scanning is unchanged.
- Undefined: all DIGITS digits always decoded, including leading zeros.

Test Plan:
- Reset with count=0: bcd=0x00000, bcd_valid never pulses, an=00001, seg=0111111.
- count 0->99 held steady: busy high 16 cycles; bcd=0x00099 exactly 16 edges after capture; single bcd_valid pulse.
- count=65535: bcd=0x65535; count=10: bcd=0x00010. Each gets one bcd_valid pulse.
- count 5, then 6 and 7 while busy: bcd=0x00005 first, then exactly one more conversion giving bcd=0x00007, two pulses total.
- REFRESH_DIV=4, bcd=0x00009:
  - an steps 00001->00010->00100->01000->10000->00001, every 4 cycles.
  - seg=1101111 while an=00001.
  - Other digits show 0111111, or 0000000 with LEADING_ZERO_BLANK_EN.
- Assert reset 5 cycles into a conversion of 99: busy=0, bcd=0, no pulse. After release a fresh 16-cycle conversion completes with bcd=0x00099.
